// File: rtl/fire_control_if.sv
// Bundle between the fire-request stage and its environment: keyboard/frame inputs,
// the mover's in-flight flag, and the fire request plus status outputs.
interface fire_control_if;
    logic [9:0]  keyIsPressed;
    logic        startOfFrame;
    logic        enable_sof;
    logic        proj_active;
    logic        fire_out;
    logic        busy;
    logic [3:0]  ammo;
    logic [15:0] shots_fired;
    logic        dry_fire;

    // Driver side: keyboard, frame timing and mover feedback.
    modport master (
        output keyIsPressed, startOfFrame, enable_sof, proj_active,
        input  fire_out, busy, ammo, shots_fired, dry_fire
    );

    // fire_control side.
    modport slave (
        input  keyIsPressed, startOfFrame, enable_sof, proj_active,
        output fire_out, busy, ammo, shots_fired, dry_fire
    );
endinterface

// File: rtl/fire_control.sv
// Fire-request stage ahead of the projectile mover: edge/level fire detection, a limited
// ammo pool refilled one round per RELOAD_FRAMES ticks, a fire timeout, and a post-shot
// cooldown so a held key cannot machine-gun.
module fire_control #(
    parameter int unsigned FIRE_KEY            = 8,
    parameter int unsigned MAX_AMMO            = 5,
    parameter int unsigned RELOAD_FRAMES       = 60,
    parameter int unsigned COOLDOWN_FRAMES     = 8,
    parameter int unsigned FIRE_TIMEOUT_FRAMES = 2,
    parameter bit          AUTO_FIRE           = 1'b0
) (
    input  logic          clk,
    input  logic          resetN,
    fire_control_if.slave bus
);

    localparam logic [3:0] AmmoMax     = 4'(MAX_AMMO);
    localparam logic [7:0] ReloadLast  = 8'(RELOAD_FRAMES - 1);
    localparam logic [7:0] TimeoutLast = 8'(FIRE_TIMEOUT_FRAMES - 1);
    // Guarded so a zero cooldown does not wrap; that case bypasses the counter anyway.
    localparam logic [7:0] CoolLast    = (COOLDOWN_FRAMES == 0) ? 8'd0 : 8'(COOLDOWN_FRAMES - 1);

    typedef enum logic [1:0] {IdleSt, FireSt, FlightSt, CooldownSt} state_e;

    state_e      state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  reload_cnt_q, reload_cnt_d;
    logic [3:0]  ammo_q, ammo_d;
    logic [15:0] shots_q;
    logic        key_prev_q;
    logic        fire_q, busy_q, dry_q;

    logic key, press, tick, accept, dry, reload_hit;
    logic keys_unused;

    assign key         = bus.keyIsPressed[FIRE_KEY];
    assign keys_unused = ^bus.keyIsPressed;
    assign press       = AUTO_FIRE ? key : (key & ~key_prev_q);
    assign tick        = bus.startOfFrame & bus.enable_sof;

    // Shot lifecycle: next state, frame counter, accept / dry-fire decisions.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        accept      = 1'b0;
        dry         = 1'b0;
        unique case (state_q)
            IdleSt: begin
                if (press && bus.enable_sof) begin
                    if (ammo_q != 4'd0) begin
                        accept      = 1'b1;
                        state_d     = FireSt;
                        frame_cnt_d = 8'd0;
                    end else begin
                        dry = 1'b1;
                    end
                end
            end
            FireSt: begin
                // The mover picking up the shot wins over a coincident timeout tick.
                if (bus.proj_active) begin
                    state_d = FlightSt;
                end else if (tick) begin
                    if (frame_cnt_q == TimeoutLast) begin
                        state_d     = CooldownSt;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            FlightSt: begin
                if (!bus.proj_active) begin
                    state_d     = CooldownSt;
                    frame_cnt_d = 8'd0;
                end
            end
            CooldownSt: begin
                if (COOLDOWN_FRAMES == 0) begin
                    state_d = IdleSt;
                end else if (tick) begin
                    if (frame_cnt_q == CoolLast) begin
                        state_d     = IdleSt;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IdleSt;
        endcase
    end

    // Ammo pool and reload timer; a reload and a consume in the same cycle cancel out.
    always_comb begin
        reload_hit   = tick && (ammo_q < AmmoMax) && (reload_cnt_q == ReloadLast);
        ammo_d       = ammo_q;
        reload_cnt_d = reload_cnt_q;
        if (ammo_q >= AmmoMax) begin
            reload_cnt_d = 8'd0;
        end else if (tick) begin
            reload_cnt_d = reload_hit ? 8'd0 : reload_cnt_q + 8'd1;
        end
        if (accept && !reload_hit) begin
            ammo_d = ammo_q - 4'd1;
        end else if (reload_hit && !accept) begin
            ammo_d = ammo_q + 4'd1;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IdleSt;
            frame_cnt_q  <= 8'd0;
            reload_cnt_q <= 8'd0;
            ammo_q       <= AmmoMax;
            shots_q      <= 16'd0;
            key_prev_q   <= 1'b0;
            fire_q       <= 1'b0;
            busy_q       <= 1'b0;
            dry_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            reload_cnt_q <= reload_cnt_d;
            ammo_q       <= ammo_d;
            shots_q      <= accept ? shots_q + 16'd1 : shots_q;
            key_prev_q   <= key;
            fire_q       <= (state_d == FireSt);
            busy_q       <= (state_d != IdleSt);
            dry_q        <= dry;
        end
    end

    assign bus.fire_out    = fire_q;
    assign bus.busy        = busy_q;
    assign bus.ammo        = ammo_q;
    assign bus.shots_fired = shots_q;
    assign bus.dry_fire    = dry_q;

endmodule

// File: tb/tb_fire_control.sv
// Directed bench for fire_control with default parameters.
module tb_fire_control;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    fire_control_if bus ();

    fire_control dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        bus.startOfFrame = 1'b1;
        cycle();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_pulse();
    endtask

    // One shot: press, mover picks up at once, flies one frame, then full cooldown.
    task automatic do_shot();
        bus.keyIsPressed[8] = 1'b1;
        cycle();
        bus.keyIsPressed[8] = 1'b0;
        bus.proj_active     = 1'b1;
        cycle();
        tick_pulse();
        bus.proj_active = 1'b0;
        cycle();
        ticks(8);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetN           = 1'b0;
        bus.keyIsPressed = '0;
        bus.startOfFrame = 1'b0;
        bus.enable_sof   = 1'b1;
        bus.proj_active  = 1'b0;
        cycle();
        cycle();

        // Reset state.
        check("rst_fire", 32'(bus.fire_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ammo", 32'(bus.ammo), 32'd5);
        check("rst_shots", 32'(bus.shots_fired), 32'd0);
        check("rst_dry", 32'(bus.dry_fire), 32'd0);
        resetN = 1'b1;
        cycle();

        // Single press, mover responds three cycles later.
        bus.keyIsPressed[8] = 1'b1;
        cycle();
        bus.keyIsPressed[8] = 1'b0;
        check("s1_fire", 32'(bus.fire_out), 32'd1);
        check("s1_busy", 32'(bus.busy), 32'd1);
        check("s1_ammo", 32'(bus.ammo), 32'd4);
        check("s1_shots", 32'(bus.shots_fired), 32'd1);
        cycle();
        cycle();
        bus.proj_active = 1'b1;
        check("s1_fire_wait", 32'(bus.fire_out), 32'd1);
        cycle();
        check("s1_fire_flight", 32'(bus.fire_out), 32'd0);
        check("s1_busy_flight", 32'(bus.busy), 32'd1);

        // Cooldown with the key held throughout.
        bus.proj_active     = 1'b0;
        bus.keyIsPressed[8] = 1'b1;
        cycle();
        check("cd_busy", 32'(bus.busy), 32'd1);
        ticks(7);
        check("cd_busy_7", 32'(bus.busy), 32'd1);
        tick_pulse();
        check("cd_idle_8", 32'(bus.busy), 32'd0);
        cycle();
        cycle();
        cycle();
        check("held_shots", 32'(bus.shots_fired), 32'd1);
        check("held_fire", 32'(bus.fire_out), 32'd0);
        bus.keyIsPressed[8] = 1'b0;
        cycle();
        bus.keyIsPressed[8] = 1'b1;
        cycle();
        bus.keyIsPressed[8] = 1'b0;
        check("repress_fire", 32'(bus.fire_out), 32'd1);
        check("repress_shots", 32'(bus.shots_fired), 32'd2);
        check("repress_ammo", 32'(bus.ammo), 32'd3);

        // Fresh start for the ammo-pool tests.
        resetN = 1'b0;
        cycle();
        resetN = 1'b1;
        cycle();
        check("rst2_ammo", 32'(bus.ammo), 32'd5);

        // Five shots (45 reload ticks elapse), then a dry fire.
        for (int s = 0; s < 5; s++) do_shot();
        check("empty_ammo", 32'(bus.ammo), 32'd0);
        check("empty_shots", 32'(bus.shots_fired), 32'd5);
        check("empty_busy", 32'(bus.busy), 32'd0);
        bus.keyIsPressed[8] = 1'b1;
        cycle();
        bus.keyIsPressed[8] = 1'b0;
        check("dry_pulse", 32'(bus.dry_fire), 32'd1);
        check("dry_fire_out", 32'(bus.fire_out), 32'd0);
        check("dry_ammo", 32'(bus.ammo), 32'd0);
        check("dry_busy", 32'(bus.busy), 32'd0);
        cycle();
        check("dry_one_cycle", 32'(bus.dry_fire), 32'd0);

        // Reload: counter sits at 45, so the 15th further tick refills.
        ticks(14);
        check("reload_pre", 32'(bus.ammo), 32'd0);
        tick_pulse();
        check("reload_hit", 32'(bus.ammo), 32'd1);
        ticks(59);
        check("reload2_pre", 32'(bus.ammo), 32'd1);
        // Press on the reload tick: consume and reload cancel.
        bus.keyIsPressed[8] = 1'b1;
        tick_pulse();
        bus.keyIsPressed[8] = 1'b0;
        check("cancel_ammo", 32'(bus.ammo), 32'd1);
        check("cancel_shots", 32'(bus.shots_fired), 32'd6);
        check("cancel_fire", 32'(bus.fire_out), 32'd1);

        // Timeout: mover never answers, two ticks abandon the shot.
        tick_pulse();
        check("to_fire_1", 32'(bus.fire_out), 32'd1);
        tick_pulse();
        check("to_fire_2", 32'(bus.fire_out), 32'd0);
        check("to_busy", 32'(bus.busy), 32'd1);
        check("to_ammo", 32'(bus.ammo), 32'd1);
        check("to_shots", 32'(bus.shots_fired), 32'd6);
        ticks(8);
        check("to_idle", 32'(bus.busy), 32'd0);

        // Frozen: reload counter now at 10; no shot, no dry fire, no counting.
        bus.enable_sof      = 1'b0;
        bus.keyIsPressed[8] = 1'b1;
        cycle();
        bus.keyIsPressed[8] = 1'b0;
        check("frz_fire", 32'(bus.fire_out), 32'd0);
        check("frz_dry", 32'(bus.dry_fire), 32'd0);
        ticks(20);
        check("frz_busy", 32'(bus.busy), 32'd0);
        check("frz_shots", 32'(bus.shots_fired), 32'd6);
        check("frz_ammo", 32'(bus.ammo), 32'd1);
        bus.enable_sof = 1'b1;
        ticks(49);
        check("frz_reload_pre", 32'(bus.ammo), 32'd1);
        tick_pulse();
        check("frz_reload_hit", 32'(bus.ammo), 32'd2);

        // FIRE_ST holds fire_out while frozen, then reset in FLIGHT_ST.
        bus.keyIsPressed[8] = 1'b1;
        cycle();
        bus.keyIsPressed[8] = 1'b0;
        bus.enable_sof      = 1'b0;
        ticks(5);
        check("frz_fire_hold", 32'(bus.fire_out), 32'd1);
        check("frz_fire_ammo", 32'(bus.ammo), 32'd1);
        bus.proj_active = 1'b1;
        cycle();
        check("fl_fire", 32'(bus.fire_out), 32'd0);
        check("fl_busy", 32'(bus.busy), 32'd1);
        resetN = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ammo", 32'(bus.ammo), 32'd5);
        check("mid_rst_shots", 32'(bus.shots_fired), 32'd0);
        check("mid_rst_fire", 32'(bus.fire_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
